// File: rtl/clock_pkg.sv
// Shared encodings and constants for the 1-hour clock mode controller.
// HOLD_REPEAT_EN (optional macro) uses the repeat fractions below.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_MIN = 2'd1,
        MODE_SET_SEC = 2'd2
    } mode_e;

    // Auto-repeat timing as fractions of CLK_HZ: first repeat after 1/2 s, then every 1/10 s.
    localparam int unsigned REP_DELAY_DIV  = 2;
    localparam int unsigned REP_PERIOD_DIV = 10;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-FF synchroniser, stability counter, registered press pulse on 0->1 only.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYC = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = cnt_width(DEB_CYC);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Clock sequencing controller: 1 Hz prescaler, RUN/SET_MIN/SET_SEC FSM, button debounce, blink.
// Optional macro HOLD_REPEAT_EN adds inc auto-repeat while held in the set states.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned DEB_CYC   = 1000000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_ca,
    output logic       sec_en,
    output logic       sec_clr,
    output logic       min_en,
    output logic       blank_min,
    output logic       blank_sec,
    output logic [1:0] mode
);

    localparam int unsigned PW = cnt_width(CLK_HZ);
    localparam int unsigned BW = cnt_width(BLINK_DIV);

    mode_e         state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          mode_level, mode_press;
    logic          inc_level, inc_pulse, inc_press;
    logic          inc_act, tick;
    logic          unused_level;

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb_mode (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (btn_mode),
        .level(mode_level),
        .press(mode_press)
    );

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb_inc (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (btn_inc),
        .level(inc_level),
        .press(inc_pulse)
    );

`ifdef HOLD_REPEAT_EN
    logic [PW-1:0] rep_cnt_q, rep_cnt_d;
    logic [PW-1:0] rep_lim;
    logic          rep_first_q, rep_first_d;
    logic          rep_q, rep_d;

    assign rep_lim = rep_first_q ? PW'(CLK_HZ / REP_DELAY_DIV - 1)
                                 : PW'(CLK_HZ / REP_PERIOD_DIV - 1);

    always_comb begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
        rep_d       = 1'b0;
        if (inc_level && (state_q != MODE_RUN) && !mode_press) begin
            rep_first_d = rep_first_q;
            if (rep_cnt_q == rep_lim) begin
                rep_first_d = 1'b0;
                rep_d       = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            rep_q       <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            rep_q       <= rep_d;
        end
    end

    assign inc_press    = inc_pulse | rep_q;
    assign unused_level = mode_level;
`else
    assign inc_press    = inc_pulse;
    assign unused_level = mode_level ^ inc_level;
`endif

    assign tick = (presc_q == PW'(CLK_HZ - 1));
    // A mode press always changes state, so it takes priority over inc.
    assign inc_act = inc_press & ~mode_press;

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                MODE_RUN:     state_d = MODE_SET_MIN;
                MODE_SET_MIN: state_d = MODE_SET_SEC;
                default:      state_d = MODE_RUN;
            endcase
        end

        presc_d = '0;
        if ((state_q == MODE_RUN) && !mode_press) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // Blink restarts from phase 0 on every state change.
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if ((state_q != MODE_RUN) && !mode_press) begin
            blink_d = blink_q;
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= MODE_RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        sec_en    = tick && (state_q == MODE_RUN);
        min_en    = ((state_q == MODE_RUN) && sec_ca) || ((state_q == MODE_SET_MIN) && inc_act);
        sec_clr   = (state_q == MODE_SET_SEC) && inc_act;
        blank_min = (state_q == MODE_SET_MIN) && blink_q;
        blank_sec = (state_q == MODE_SET_SEC) && blink_q;
        mode      = state_q;
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with CLK_HZ=10, DEB_CYC=4, BLINK_DIV=3.
module tb_clock_mode_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       btn_mode, btn_inc, sec_ca;
    logic       sec_en, sec_clr, min_en, blank_min, blank_sec;
    logic [1:0] mode;

    int n_vec = 0;
    int n_bad = 0;
    int n_min, n_clr, n_bs, n_se;

    clock_mode_ctrl #(
        .CLK_HZ   (10),
        .DEB_CYC  (4),
        .BLINK_DIV(3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_ca   (sec_ca),
        .sec_en   (sec_en),
        .sec_clr  (sec_clr),
        .min_en   (min_en),
        .blank_min(blank_min),
        .blank_sec(blank_sec),
        .mode     (mode)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         n;
        logic       ca;
        logic       se;
        logic       me;
        logic       sc;
        logic [1:0] md;
        logic       bm;
        logic       bs;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive raw buttons high for 'hold' edges, then low; count output pulses over 'total' edges.
    task automatic press(input logic m, input logic i, input int hold, input int total);
        n_min = 0; n_clr = 0; n_bs = 0; n_se = 0;
        btn_mode = m;
        btn_inc  = i;
        for (int e = 1; e <= total; e++) begin
            step();
            if (e == hold) begin
                btn_mode = 1'b0;
                btn_inc  = 1'b0;
            end
            n_min += int'(min_en);
            n_clr += int'(sec_clr);
            n_bs  += int'(blank_sec);
            n_se  += int'(sec_en);
        end
    endtask

    initial begin
        bit found;
        RST = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; sec_ca = 1'b0;

        //        n  ca    se    me    sc    md    bm    bs
        tbl[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[2] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[5] = '{9, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[6] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[7] = '{9, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[8] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Free run: sec_en on the 10th, 20th, 30th cycle after release.
        for (int v = 0; v < 9; v++) begin
            repeat (tbl[v].n) step();
            sec_ca = tbl[v].ca;
            #1;
            chk($sformatf("run[%0d].sec_en", v), int'(sec_en), int'(tbl[v].se));
            chk($sformatf("run[%0d].min_en", v), int'(min_en), int'(tbl[v].me));
            chk($sformatf("run[%0d].sec_clr", v), int'(sec_clr), int'(tbl[v].sc));
            chk($sformatf("run[%0d].mode", v), int'(mode), int'(tbl[v].md));
            chk($sformatf("run[%0d].blank_min", v), int'(blank_min), int'(tbl[v].bm));
            chk($sformatf("run[%0d].blank_sec", v), int'(blank_sec), int'(tbl[v].bs));
            sec_ca = 1'b0;
        end

        // Mode press timing: press pulse DEB_CYC+2 edges after the rise, state one edge later.
        btn_mode = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 10) btn_mode = 1'b0;
            if (e == 6) chk("mode_before_entry", int'(mode), 0);
            if (e == 7) chk("mode_set_min_entry", int'(mode), 1);
            if (e >= 8) begin
                chk($sformatf("blink_min[%0d]", e - 7), int'(blank_min), ((e - 7) / 3) % 2);
                chk($sformatf("blink_sec[%0d]", e - 7), int'(blank_sec), 0);
                chk($sformatf("set_min_sec_en[%0d]", e - 7), int'(sec_en), 0);
            end
        end
        sec_ca = 1'b1;
        #1;
        chk("sec_ca_ignored_set_min", int'(min_en), 0);
        sec_ca = 1'b0;
        repeat (2) step();

        // Three inc presses in SET_MIN.
        begin
            int tot_min = 0, tot_clr = 0, tot_bs = 0;
            for (int p = 0; p < 3; p++) begin
                press(1'b0, 1'b1, 8, 20);
                tot_min += n_min; tot_clr += n_clr; tot_bs += n_bs;
            end
            chk("set_min_inc_pulses", tot_min, 3);
            chk("set_min_sec_clr", tot_clr, 0);
            chk("set_min_blank_sec", tot_bs, 0);
            chk("mode_still_set_min", int'(mode), 1);
        end

        press(1'b1, 1'b0, 8, 20);
        chk("mode_set_sec", int'(mode), 2);
        chk("mode_press_no_min_en", n_min, 0);

        press(1'b0, 1'b1, 8, 20);
        chk("set_sec_clr_pulses", n_clr, 1);
        chk("set_sec_no_min_en", n_min, 0);
        chk("mode_still_set_sec", int'(mode), 2);

        // Mode and inc land together: mode wins; then first sec_en exactly 10 cycles into RUN.
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        n_clr = 0; n_min = 0;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 8) begin
                btn_mode = 1'b0;
                btn_inc  = 1'b0;
            end
            n_clr += int'(sec_clr);
            n_min += int'(min_en);
            if (e == 6) chk("simul_mode_before", int'(mode), 2);
            if (e == 7) chk("simul_mode_run", int'(mode), 0);
            if (e >= 8) chk($sformatf("reentry_sec_en[%0d]", e - 7), int'(sec_en),
                            (e == 16) ? 1 : 0);
        end
        chk("simul_no_sec_clr", n_clr, 0);
        chk("simul_no_min_en", n_min, 0);
        repeat (4) step();

        press(1'b1, 1'b0, 8, 20);
        press(1'b1, 1'b0, 8, 20);
        chk("mode_back_set_sec", int'(mode), 2);

        // Bouncing inc: 1-0-1 at 2-clock intervals never settles.
        n_clr = 0;
        btn_inc = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 2) btn_inc = 1'b0;
            if (e == 4) btn_inc = 1'b1;
            if (e == 6) btn_inc = 1'b0;
            n_clr += int'(sec_clr);
        end
        chk("bounce_no_sec_clr", n_clr, 0);

        // Async reset mid-SET_SEC while the seconds digits are blanked.
        found = 1'b0;
        for (int e = 0; e < 8 && !found; e++) begin
            step();
            if (blank_sec) found = 1'b1;
        end
        chk("blank_sec_seen", int'(found), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mode", int'(mode), 0);
        chk("rst_blank_sec", int'(blank_sec), 0);
        chk("rst_blank_min", int'(blank_min), 0);
        chk("rst_sec_en", int'(sec_en), 0);
        chk("rst_min_en", int'(min_en), 0);
        chk("rst_sec_clr", int'(sec_clr), 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) step();
        chk("post_rst_sec_en_early", int'(sec_en), 0);
        step();
        chk("post_rst_sec_en", int'(sec_en), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
